// File: rtl/ps2_pkg.sv
// Shared constants, state encoding and helpers for the PS/2 scan-code receiver.
package ps2_pkg;

    // Prefix bytes folded into event flags
    localparam logic [7:0] PS2_PREFIX_EXT   = 8'hE0;
    localparam logic [7:0] PS2_PREFIX_BREAK = 8'hF0;

    // Start + 8 data + parity + stop
    localparam int unsigned PS2_FRAME_BITS = 11;
    localparam int unsigned PS2_DATA_BITS  = PS2_FRAME_BITS - 3;

    // Frame receiver states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_e;

    // Odd parity over data and parity bit
    function automatic logic ps2_parity_ok(input logic [7:0] data, input logic parity);
        return ^{data, parity};
    endfunction

    // True for bytes that only set a pending flag and never produce an event
    function automatic logic ps2_is_prefix(input logic [7:0] data);
        return (data == PS2_PREFIX_EXT) || (data == PS2_PREFIX_BREAK);
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Conditions one raw PS/2 line: 2-FF synchronizer followed by a glitch filter.
// The filtered value follows the synchronized line only after FILTER_LEN
// consecutive samples that disagree with the current filtered value.
module ps2_line_filter #(
    parameter int unsigned FILTER_LEN = 16
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_line,
    output logic o_filtered
);

    localparam int unsigned       CNT_W    = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(FILTER_LEN - 1);

    logic [1:0]       r_sync;
    logic [CNT_W-1:0] r_runCnt;
    logic             r_filtered;

    // Two-stage synchronizer; idles high like the PS/2 bus
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[0], i_line};
        end
    end

    // Run counter of samples differing from the filtered value; flip on a full run
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_runCnt   <= '0;
            r_filtered <= 1'b1;
        end else if (r_sync[1] == r_filtered) begin
            r_runCnt <= '0;
        end else if (r_runCnt == CNT_LAST) begin
            r_filtered <= r_sync[1];
            r_runCnt   <= '0;
        end else begin
            r_runCnt <= r_runCnt + CNT_W'(1);
        end
    end

    assign o_filtered = r_filtered;

endmodule

// File: rtl/ps2_scancode_receiver.sv
// PS/2 keyboard frame receiver: conditions the lines, deframes and checks
// 11-bit frames, folds E0/F0 prefixes into flags, and presents each key
// event on a one-deep valid/ready output register.
module ps2_scancode_receiver
    import ps2_pkg::*;
#(
    parameter int unsigned CLOCK_FREQUNCY = 100000000,
    parameter int unsigned FILTER_LEN     = 16,
    parameter int unsigned TIMEOUT_CYCLES = CLOCK_FREQUNCY / 500
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2Clk,
    input  logic       ps2Data,
    output logic [7:0] scanCode,
    output logic       isExtended,
    output logic       isBreak,
    output logic       codeValid,
    input  logic       codeReady,
    output logic       frameError,
    output logic       overflow
);

    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYCLES);
    localparam logic [2:0]      BIT_LAST = 3'(PS2_DATA_BITS - 1);

    // Conditioned lines and edge detect
    logic w_clkFilt;
    logic w_dataFilt;
    logic r_clkPrev;
    logic w_sampleEn;

    // Frame receiver
    ps2_state_e      r_state;
    logic [7:0]      r_shift;
    logic [2:0]      r_bitCnt;
    logic            r_parity;
    logic [TO_W-1:0] r_toCnt;
    logic [7:0]      r_byte;
    logic            r_byteStrobe;
    logic            r_frameErr;

    // Prefix folding and output register
    logic       r_extPending;
    logic       r_brkPending;
    logic       w_emit;
    logic [7:0] r_scanCode;
    logic       r_isExt;
    logic       r_isBrk;
    logic       r_codeValid;
    logic       r_overflow;

    ps2_line_filter #(
        .FILTER_LEN(FILTER_LEN)
    ) u_clkFilter (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_line     (ps2Clk),
        .o_filtered (w_clkFilt)
    );

    ps2_line_filter #(
        .FILTER_LEN(FILTER_LEN)
    ) u_dataFilter (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_line     (ps2Data),
        .o_filtered (w_dataFilt)
    );

    // Previous filtered clock, for falling-edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_clkPrev <= 1'b1;
        end else begin
            r_clkPrev <= w_clkFilt;
        end
    end

    assign w_sampleEn = r_clkPrev & ~w_clkFilt;

    // Frame FSM with inactivity timeout; emits a byte strobe or an error pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_shift      <= '0;
            r_bitCnt     <= '0;
            r_parity     <= 1'b0;
            r_toCnt      <= '0;
            r_byte       <= '0;
            r_byteStrobe <= 1'b0;
            r_frameErr   <= 1'b0;
        end else begin
            r_byteStrobe <= 1'b0;
            r_frameErr   <= 1'b0;
            if ((r_state != ST_IDLE) && (r_toCnt == TO_LIMIT)) begin
                // Abandoned partial frame
                r_state    <= ST_IDLE;
                r_toCnt    <= '0;
                r_frameErr <= 1'b1;
            end else if (w_sampleEn) begin
                r_toCnt <= '0;
                case (r_state)
                    ST_IDLE: begin
                        if (!w_dataFilt) begin
                            r_state  <= ST_DATA;
                            r_bitCnt <= '0;
                        end
                    end
                    ST_DATA: begin
                        r_shift  <= {w_dataFilt, r_shift[7:1]};
                        r_bitCnt <= r_bitCnt + 3'd1;
                        if (r_bitCnt == BIT_LAST) begin
                            r_state <= ST_PARITY;
                        end
                    end
                    ST_PARITY: begin
                        r_parity <= w_dataFilt;
                        r_state  <= ST_STOP;
                    end
                    ST_STOP: begin
                        r_state <= ST_IDLE;
                        if (w_dataFilt && ps2_parity_ok(r_shift, r_parity)) begin
                            r_byte       <= r_shift;
                            r_byteStrobe <= 1'b1;
                        end else begin
                            r_frameErr <= 1'b1;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end else if (r_state == ST_IDLE) begin
                r_toCnt <= '0;
            end else begin
                r_toCnt <= r_toCnt + TO_W'(1);
            end
        end
    end

    // A non-prefix byte becomes a key event
    always_comb begin
        w_emit = r_byteStrobe && !ps2_is_prefix(r_byte);
    end

    // Pending prefix flags: set by E0/F0, cleared by any event or frame error
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_extPending <= 1'b0;
            r_brkPending <= 1'b0;
        end else if (r_frameErr) begin
            r_extPending <= 1'b0;
            r_brkPending <= 1'b0;
        end else if (r_byteStrobe) begin
            if (r_byte == PS2_PREFIX_EXT) begin
                r_extPending <= 1'b1;
            end else if (r_byte == PS2_PREFIX_BREAK) begin
                r_brkPending <= 1'b1;
            end else begin
                r_extPending <= 1'b0;
                r_brkPending <= 1'b0;
            end
        end
    end

    // One-deep output register; a new event while full and not accepted is dropped
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_scanCode  <= '0;
            r_isExt     <= 1'b0;
            r_isBrk     <= 1'b0;
            r_codeValid <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_overflow <= 1'b0;
            if (w_emit) begin
                if (!r_codeValid || codeReady) begin
                    r_scanCode  <= r_byte;
                    r_isExt     <= r_extPending;
                    r_isBrk     <= r_brkPending;
                    r_codeValid <= 1'b1;
                end else begin
                    r_overflow <= 1'b1;
                end
            end else if (r_codeValid && codeReady) begin
                r_codeValid <= 1'b0;
            end
        end
    end

    assign scanCode   = r_scanCode;
    assign isExtended = r_isExt;
    assign isBreak    = r_isBrk;
    assign codeValid  = r_codeValid;
    assign frameError = r_frameErr;
    assign overflow   = r_overflow;

endmodule

// File: tb/tb_ps2_scancode_receiver.sv
// Randomized and directed bench for ps2_scancode_receiver with a key-event
// reference model (prefix folding, error and overflow rules) and a scoreboard.
module tb_ps2_scancode_receiver;

    localparam int unsigned FILTER_LEN = 16;
    localparam int unsigned TIMEOUT    = 1000;
    localparam int unsigned HALF       = 50;   // half bit period in clk cycles
    localparam int unsigned LAT_MAX    = FILTER_LEN + 5;

    logic       clk = 1'b0;
    logic       rst;
    logic       ps2Clk;
    logic       ps2Data;
    logic [7:0] scanCode;
    logic       isExtended;
    logic       isBreak;
    logic       codeValid;
    logic       codeReady;
    logic       frameError;
    logic       overflow;

    ps2_scancode_receiver #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ps2Clk     (ps2Clk),
        .ps2Data    (ps2Data),
        .scanCode   (scanCode),
        .isExtended (isExtended),
        .isBreak    (isBreak),
        .codeValid  (codeValid),
        .codeReady  (codeReady),
        .frameError (frameError),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int unsigned nChecks = 0;
    int unsigned nErrors = 0;

    // Reference model state
    logic [9:0]  expQ[$];          // {code, ext, brk}
    logic        mExt = 1'b0;
    logic        mBrk = 1'b0;
    logic        mHeld = 1'b0;
    int unsigned expErr = 0;
    int unsigned expOvf = 0;

    // Observed activity
    int unsigned errCnt = 0;
    int unsigned ovfCnt = 0;
    int unsigned tStopFall = 0;
    logic        stopSeen = 1'b0;
    logic        prevValid = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nErrors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    // Reference model for one frame as the keyboard sends it
    task automatic model_frame(input logic [7:0] b, input bit ok);
        if (!ok) begin
            expErr++;
            mExt = 1'b0;
            mBrk = 1'b0;
        end else if (b == 8'hE0) begin
            mExt = 1'b1;
        end else if (b == 8'hF0) begin
            mBrk = 1'b1;
        end else begin
            if (mHeld) begin
                expOvf++;
            end else begin
                expQ.push_back({b, mExt, mBrk});
                mHeld = !codeReady;
            end
            mExt = 1'b0;
            mBrk = 1'b0;
        end
    endtask

    // Drive the first nbits bits of a frame; optional 3-cycle clock glitch
    task automatic send_frame(input logic [7:0] b, input bit badPar, input bit badStop,
                              input int unsigned nbits, input int glitchBit);
        logic [10:0] f;
        f = {~badStop, (~^b) ^ badPar, b, 1'b0};
        for (int i = 0; i < int'(nbits); i++) begin
            ps2Data = f[i];
            if (i == glitchBit) begin
                wait_cyc(HALF / 2);
                ps2Clk = 1'b0;
                wait_cyc(3);
                ps2Clk = 1'b1;
                wait_cyc(HALF - HALF / 2 - 3);
            end else begin
                wait_cyc(HALF);
            end
            ps2Clk = 1'b0;
            if (i == 10) begin
                tStopFall = cyc;
                stopSeen  = 1'b1;
            end
            wait_cyc(HALF);
            ps2Clk = 1'b1;
        end
        wait_cyc(HALF);
        ps2Data = 1'b1;
    endtask

    task automatic send_good(input logic [7:0] b);
        model_frame(b, 1'b1);
        send_frame(b, 1'b0, 1'b0, 11, -1);
        wait_cyc(40);
    endtask

    task automatic set_ready(input logic v);
        @(posedge clk);
        #1 codeReady = v;
    endtask

    task automatic end_scenario(input string tag);
        wait_cyc(40);
        check_eq({tag, "_frameErr"}, errCnt, expErr);
        check_eq({tag, "_overflow"}, ovfCnt, expOvf);
        check_eq({tag, "_codes_left"}, expQ.size(), 0);
    endtask

    // Monitor: scoreboard on handshakes, pulse counting, latency bound
    always @(negedge clk) begin
        if (!rst) begin
            if (frameError) errCnt++;
            if (overflow)   ovfCnt++;
            if (codeValid && !prevValid && stopSeen)
                check_eq("latency_in_bound", (cyc - tStopFall) <= LAT_MAX, 1);
            if (codeValid && codeReady) begin
                check_eq("code_expected", expQ.size() > 0, 1);
                if (expQ.size() > 0)
                    check_eq("code", {scanCode, isExtended, isBreak}, expQ.pop_front());
            end
        end
        prevValid = codeValid;
    end

    initial begin
        #20_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  b;
        int unsigned r;
        bit          bp;
        bit          bs;

        rst       = 1'b1;
        ps2Clk    = 1'b1;
        ps2Data   = 1'b1;
        codeReady = 1'b0;
        wait_cyc(5);
        check_eq("rst_codeValid",  codeValid, 0);
        check_eq("rst_scanCode",   scanCode, 0);
        check_eq("rst_isExtended", isExtended, 0);
        check_eq("rst_isBreak",    isBreak, 0);
        check_eq("rst_frameError", frameError, 0);
        check_eq("rst_overflow",   overflow, 0);
        rst = 1'b0;
        wait_cyc(40);

        // Single code held until accepted
        send_good(8'h1C);
        check_eq("hold_valid", codeValid, 1);
        check_eq("hold_code",  scanCode, 8'h1C);
        check_eq("hold_ext",   isExtended, 0);
        check_eq("hold_brk",   isBreak, 0);
        wait_cyc(100);
        check_eq("hold_valid_later", codeValid, 1);
        check_eq("hold_code_later",  scanCode, 8'h1C);
        set_ready(1'b1);
        set_ready(1'b0);
        mHeld = 1'b0;
        @(negedge clk);
        check_eq("hold_valid_drop", codeValid, 0);
        end_scenario("hold");

        // Prefixes fold into one event
        set_ready(1'b1);
        send_good(8'hE0);
        send_good(8'hF0);
        check_eq("prefix_no_output", codeValid, 0);
        send_good(8'h75);
        end_scenario("prefix");

        // Bad parity, then good frame
        model_frame(8'h1C, 1'b0);
        send_frame(8'h1C, 1'b1, 1'b0, 11, -1);
        wait_cyc(40);
        check_eq("badpar_no_valid", codeValid, 0);
        check_eq("badpar_err", errCnt, expErr);
        send_good(8'h1C);
        end_scenario("badpar");

        // Bad stop bit, with a pending prefix that must be discarded
        send_good(8'hE0);
        model_frame(8'h1C, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b1, 11, -1);
        wait_cyc(40);
        check_eq("badstop_no_valid", codeValid, 0);
        send_good(8'h1C);
        end_scenario("badstop");

        // Partial frame abandoned by timeout
        model_frame(8'h00, 1'b0);
        send_frame(8'h5A, 1'b0, 1'b0, 6, -1);
        wait_cyc(TIMEOUT + 100);
        check_eq("timeout_err", errCnt, expErr);
        send_good(8'h29);
        end_scenario("timeout");

        // Overflow while consumer stalls
        set_ready(1'b0);
        send_good(8'h1C);
        send_good(8'h32);
        check_eq("ovf_valid", codeValid, 1);
        check_eq("ovf_code_kept", scanCode, 8'h1C);
        check_eq("ovf_pulses", ovfCnt, 1);
        set_ready(1'b1);
        set_ready(1'b0);
        mHeld = 1'b0;
        end_scenario("ovf");

        // Short glitch on ps2Clk mid-bit
        set_ready(1'b1);
        model_frame(8'h1C, 1'b1);
        send_frame(8'h1C, 1'b0, 1'b0, 11, 4);
        end_scenario("glitch");

        // Reset during data bit 4 with a held code
        set_ready(1'b0);
        send_good(8'h4B);
        send_frame(8'h1C, 1'b0, 1'b0, 5, -1);
        b = 8'h1C;
        ps2Data = b[4];
        wait_cyc(20);
        rst = 1'b1;
        #1;
        check_eq("arst_codeValid", codeValid, 0);
        check_eq("arst_scanCode",  scanCode, 0);
        check_eq("arst_isExt",     isExtended, 0);
        check_eq("arst_isBrk",     isBreak, 0);
        expQ.delete();
        mHeld    = 1'b0;
        mExt     = 1'b0;
        mBrk     = 1'b0;
        stopSeen = 1'b0;
        wait_cyc(5);
        ps2Data = 1'b1;
        rst = 1'b0;
        wait_cyc(40);
        set_ready(1'b1);
        send_good(8'h1C);
        end_scenario("arst");

        // Randomized event stream with occasional corrupted frames
        for (int n = 0; n < 24; n++) begin
            r = $urandom_range(0, 9);
            if (r < 2)       b = 8'hE0;
            else if (r == 2) b = 8'hF0;
            else if (r == 3) b = 8'hE1;
            else             b = 8'($urandom_range(0, 255));
            bp = 1'b0;
            bs = 1'b0;
            if ($urandom_range(0, 7) == 0) begin
                if ($urandom_range(0, 1) == 0) bp = 1'b1;
                else                           bs = 1'b1;
            end
            model_frame(b, !(bp || bs));
            send_frame(b, bp, bs, 11, -1);
            wait_cyc(30 + $urandom_range(0, 150));
        end
        end_scenario("random");

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule
